// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU: opcodes, sequencer
// states, ALU function codes and accumulator source selects.
package acc_cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LDR = 4'h2;
  localparam logic [3:0] OP_STR = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_NOT = 4'h9;
  localparam logic [3:0] OP_SHL = 4'hA;
  localparam logic [3:0] OP_SHR = 4'hB;
  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_JZ  = 4'hD;
  localparam logic [3:0] OP_JNZ = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_JUMP,
    ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOT,
    ALU_SHL,
    ALU_SHR
  } alu_op_t;

  localparam logic [1:0] SEL_IMM = 2'b00;
  localparam logic [1:0] SEL_RF  = 2'b01;
  localparam logic [1:0] SEL_ALU = 2'b10;

  function automatic logic jump_taken(input logic [3:0] opcode, input logic [7:0] acc);
    case (opcode)
      OP_JMP:  return 1'b1;
      OP_JZ:   return acc == 8'h00;
      OP_JNZ:  return acc != 8'h00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/acc_sequencer_if.sv
// Instruction-memory and datapath control bundle between the sequencer
// (master) and the memory/accumulator/register-file side (slave).
interface acc_sequencer_if;
  logic       start;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic [7:0] acc_out;
  logic       load_acc;
  logic [1:0] sel_acc;
  logic [3:0] immediate;
  logic [3:0] rf_addr;
  logic       rf_we;
  logic [2:0] alu_op;
  logic [7:0] pc;
  logic       halted;

  modport master (
    input  start, imem_data, acc_out,
    output imem_addr, load_acc, sel_acc, immediate, rf_addr, rf_we, alu_op, pc, halted
  );

  modport slave (
    output start, imem_data, acc_out,
    input  imem_addr, load_acc, sel_acc, immediate, rf_addr, rf_we, alu_op, pc, halted
  );
endinterface

// File: rtl/acc_sequencer_decode.sv
// Combinational opcode decoder: maps an instruction opcode onto the
// datapath controls it needs plus jump/halt classification.
module acc_decode
  import acc_cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       load_acc,
  output logic [1:0] sel_acc,
  output logic       rf_we,
  output alu_op_t    alu_op,
  output logic       is_jump,
  output logic       is_halt
);

  always_comb begin
    load_acc = 1'b0;
    sel_acc  = SEL_IMM;
    rf_we    = 1'b0;
    alu_op   = ALU_ADD;
    is_jump  = 1'b0;
    is_halt  = 1'b0;
    case (opcode)
      OP_LDI: begin
        load_acc = 1'b1;
        sel_acc  = SEL_IMM;
      end
      OP_LDR: begin
        load_acc = 1'b1;
        sel_acc  = SEL_RF;
      end
      OP_STR: rf_we = 1'b1;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR: begin
        load_acc = 1'b1;
        sel_acc  = SEL_ALU;
        // For opcodes 4..B, (opcode - 4) mod 8 is just bit 2 flipped.
        alu_op   = alu_op_t'(opcode[2:0] ^ 3'b100);
      end
      OP_JMP, OP_JZ, OP_JNZ: is_jump = 1'b1;
      OP_HLT: is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/acc_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the accumulator CPU;
// owns the program counter and executes two-byte conditional jumps.
module acc_sequencer
  import acc_cpu_pkg::*;
(
  input  logic            clk,
  input  logic            clb,
  acc_sequencer_if.master bus
);

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] imem_addr_q, imem_addr_d;
  logic       load_acc_q, load_acc_d;
  logic [1:0] sel_acc_q, sel_acc_d;
  logic [3:0] immediate_q, immediate_d;
  logic [3:0] rf_addr_q, rf_addr_d;
  logic       rf_we_q, rf_we_d;
  logic [2:0] alu_op_q, alu_op_d;
  logic       halted_q, halted_d;
  logic       entering_exec;

  logic       dec_load_acc;
  logic [1:0] dec_sel_acc;
  logic       dec_rf_we;
  alu_op_t    dec_alu_op;
  logic       dec_is_jump;
  logic       dec_is_halt;

  // Decoding the next ir lets every control output be a plain flop while
  // still being valid in the EXEC cycle itself.
  always_comb begin
    ir_d = ir_q;
    if (state_q == ST_DECODE) ir_d = bus.imem_data;
  end

  acc_decode u_decode (
    .opcode   (ir_d[7:4]),
    .load_acc (dec_load_acc),
    .sel_acc  (dec_sel_acc),
    .rf_we    (dec_rf_we),
    .alu_op   (dec_alu_op),
    .is_jump  (dec_is_jump),
    .is_halt  (dec_is_halt)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (bus.start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        pc_d    = pc_q + 8'd1;
        state_d = ST_DECODE;
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        if (dec_is_jump) begin
          pc_d    = pc_q + 8'd1;
          state_d = ST_JUMP;
        end else if (dec_is_halt) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_JUMP: begin
        if (jump_taken(ir_q[7:4], bus.acc_out)) pc_d = bus.imem_data;
        state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase

    entering_exec = (state_d == ST_EXEC);
    load_acc_d    = entering_exec & dec_load_acc;
    rf_we_d       = entering_exec & dec_rf_we;
    sel_acc_d     = entering_exec ? dec_sel_acc : '0;
    alu_op_d      = entering_exec ? 3'(dec_alu_op) : '0;
    immediate_d   = entering_exec ? ir_d[3:0] : '0;
    rf_addr_d     = entering_exec ? ir_d[3:0] : '0;
    // Only a non-jump EXEC parks the memory address at zero.
    imem_addr_d   = (entering_exec && !dec_is_jump) ? '0 : pc_d;
    halted_d      = (state_d == ST_HALT);
  end

  always_ff @(posedge clk or posedge clb) begin
    if (clb) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      imem_addr_q <= '0;
      load_acc_q  <= 1'b0;
      sel_acc_q   <= '0;
      immediate_q <= '0;
      rf_addr_q   <= '0;
      rf_we_q     <= 1'b0;
      alu_op_q    <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      imem_addr_q <= imem_addr_d;
      load_acc_q  <= load_acc_d;
      sel_acc_q   <= sel_acc_d;
      immediate_q <= immediate_d;
      rf_addr_q   <= rf_addr_d;
      rf_we_q     <= rf_we_d;
      alu_op_q    <= alu_op_d;
      halted_q    <= halted_d;
    end
  end

  assign bus.imem_addr = imem_addr_q;
  assign bus.load_acc  = load_acc_q;
  assign bus.sel_acc   = sel_acc_q;
  assign bus.immediate = immediate_q;
  assign bus.rf_addr   = rf_addr_q;
  assign bus.rf_we     = rf_we_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.pc        = pc_q;
  assign bus.halted    = halted_q;

endmodule

// File: tb/tb_acc_sequencer.sv
// Bench for acc_sequencer: synchronous instruction memory, a small
// accumulator/register-file datapath, directed scenarios and random programs
// checked against an instruction-level reference model.
`timescale 1ns/1ps
module tb_acc_sequencer;
  import acc_cpu_pkg::*;

  logic clk = 1'b0;
  logic clb;
  always #5 clk = ~clk;

  acc_sequencer_if bus ();
  acc_sequencer dut (.clk(clk), .clb(clb), .bus(bus));

  int tests = 0;
  int fails = 0;

  logic [7:0] mem [256];
  logic [7:0] acc_q;
  logic [7:0] rf_q [16];

  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~a;
      3'd6: return a << 1;
      default: return a >> 1;
    endcase
  endfunction

  always @(posedge clk) bus.imem_data <= mem[bus.imem_addr];

  always @(posedge clk or posedge clb) begin
    if (clb) begin
      acc_q <= '0;
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
    end else begin
      if (bus.load_acc) begin
        case (bus.sel_acc)
          2'b00:   acc_q <= {4'h0, bus.immediate};
          2'b01:   acc_q <= rf_q[bus.rf_addr];
          default: acc_q <= alu_f(bus.alu_op, acc_q, rf_q[bus.rf_addr]);
        endcase
      end
      if (bus.rf_we) rf_q[bus.rf_addr] <= acc_q;
    end
  end
  assign bus.acc_out = acc_q;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] pc;
    logic       load;
    logic       we;
    logic       halted;
    logic [1:0] sel;
    logic [2:0] alu;
    logic [3:0] imm;
    logic [3:0] rfa;
    bit         c_sel, c_alu, c_imm, c_rfa;
  } exp_t;

  function automatic exp_t mk(input logic [7:0] addr, input logic [7:0] pc, input logic halted);
    exp_t e;
    e.addr = addr; e.pc = pc; e.load = 1'b0; e.we = 1'b0; e.halted = halted;
    e.sel = '0; e.alu = '0; e.imm = '0; e.rfa = '0;
    e.c_sel = 1'b1; e.c_alu = 1'b1; e.c_imm = 1'b1; e.c_rfa = 1'b1;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clb = 1'b1;
    bus.start = 1'b0;
    tick();
    tick();
    clb = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  // Returns sampled in cycle 1 (the first FETCH).
  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (bus.imem_addr !== 8'h00) begin fails++; $display("FAIL reset imem_addr: got %0h want 00", bus.imem_addr); end
    tests++; if (bus.pc !== 8'h00) begin fails++; $display("FAIL reset pc: got %0h want 00", bus.pc); end
    tests++; if ({bus.load_acc, bus.rf_we, bus.halted} !== 3'b000) begin fails++; $display("FAIL reset load/we/halted: got %b want 000", {bus.load_acc, bus.rf_we, bus.halted}); end
    tests++; if ({bus.sel_acc, bus.alu_op, bus.immediate, bus.rf_addr} !== 13'h0) begin fails++; $display("FAIL reset sel/alu/imm/rfa: got %0h want 0", {bus.sel_acc, bus.alu_op, bus.immediate, bus.rf_addr}); end
    for (int c = 0; c < 5; c++) begin
      tick();
      tests++; if ({bus.pc, bus.imem_addr} !== 16'h0000) begin fails++; $display("FAIL idle hold cycle %0d pc/addr: got %0h want 0000", c, {bus.pc, bus.imem_addr}); end
    end
    clear_mem();
    mem[0] = 8'h15;
    mem[1] = 8'h33;
    pulse_start();
    repeat (5) tick();
    tests++; if (bus.rf_we !== 1'b1) begin fails++; $display("FAIL STR exec rf_we before abort: got %b want 1", bus.rf_we); end
    clb = 1'b1;
    #1;
    tests++; if (bus.rf_we !== 1'b0) begin fails++; $display("FAIL rf_we after async reset: got %b want 0", bus.rf_we); end
    tick();
    clb = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      tests++; if ({bus.rf_we, bus.load_acc, bus.halted} !== 3'b000) begin fails++; $display("FAIL post-abort cycle %0d we/load/halted: got %b want 000", c, {bus.rf_we, bus.load_acc, bus.halted}); end
      tests++; if (bus.pc !== 8'h00) begin fails++; $display("FAIL post-abort cycle %0d pc: got %0h want 00", c, bus.pc); end
    end
  endtask

  task automatic test_straight_line();
    do_reset();
    clear_mem();
    mem[0] = 8'h15; mem[1] = 8'h33; mem[2] = 8'h43; mem[3] = 8'hF0;
    pulse_start();
    repeat (2) tick();
    tests++; if ({bus.load_acc, bus.sel_acc, bus.immediate} !== {1'b1, 2'b00, 4'd5}) begin fails++; $display("FAIL LDI cycle3 load/sel/imm: got %0h want %0h", {bus.load_acc, bus.sel_acc, bus.immediate}, {1'b1, 2'b00, 4'd5}); end
    repeat (3) tick();
    tests++; if ({bus.rf_we, bus.rf_addr, bus.load_acc} !== {1'b1, 4'd3, 1'b0}) begin fails++; $display("FAIL STR cycle6 we/rfa/load: got %0h want %0h", {bus.rf_we, bus.rf_addr, bus.load_acc}, {1'b1, 4'd3, 1'b0}); end
    repeat (3) tick();
    tests++; if ({bus.load_acc, bus.sel_acc, bus.alu_op, bus.rf_addr} !== {1'b1, 2'b10, 3'd0, 4'd3}) begin fails++; $display("FAIL ADD cycle9 load/sel/alu/rfa: got %0h want %0h", {bus.load_acc, bus.sel_acc, bus.alu_op, bus.rf_addr}, {1'b1, 2'b10, 3'd0, 4'd3}); end
    repeat (3) tick();
    tests++; if (bus.halted !== 1'b0) begin fails++; $display("FAIL HLT exec cycle12 halted: got %b want 0", bus.halted); end
    tick();
    tests++; if ({bus.halted, bus.pc} !== {1'b1, 8'h04}) begin fails++; $display("FAIL cycle13 halted/pc: got %0h want %0h", {bus.halted, bus.pc}, {1'b1, 8'h04}); end
    tests++; if (bus.acc_out !== 8'd10) begin fails++; $display("FAIL accumulator after program: got %0d want 10", bus.acc_out); end
  endtask

  task automatic test_jumps();
    for (int k = 0; k < 4; k++) begin
      logic [3:0] accv;
      logic [3:0] opc;
      logic [7:0] want;
      accv = (k == 0 || k == 3) ? 4'd0 : 4'd1;
      opc  = (k < 2) ? OP_JZ : OP_JNZ;
      want = (k == 0 || k == 2) ? 8'h20 : 8'h03;
      do_reset();
      clear_mem();
      mem[0] = {OP_LDI, accv}; mem[1] = {opc, 4'h0}; mem[2] = 8'h20;
      pulse_start();
      repeat (5) tick();
      tests++; if (bus.imem_addr !== 8'h02) begin fails++; $display("FAIL jump %0d target-byte addr: got %0h want 02", k, bus.imem_addr); end
      repeat (2) tick();
      tests++; if ({bus.imem_addr, bus.pc} !== {want, want}) begin fails++; $display("FAIL jump %0d next fetch addr/pc: got %0h want %0h", k, {bus.imem_addr, bus.pc}, {want, want}); end
    end
    do_reset();
    clear_mem();
    mem[0] = 8'hC0; mem[1] = 8'hFE; mem[8'hFE] = 8'hC0; mem[8'hFF] = 8'h42;
    pulse_start();
    repeat (6) tick();
    tests++; if (bus.imem_addr !== 8'hFF) begin fails++; $display("FAIL JMP@FE target-byte addr: got %0h want ff", bus.imem_addr); end
    tick();
    tests++; if (bus.pc !== 8'h00) begin fails++; $display("FAIL JMP@FE pc wrap in JUMP: got %0h want 00", bus.pc); end
    tick();
    tests++; if (bus.imem_addr !== 8'h42) begin fails++; $display("FAIL JMP@FE fetch target: got %0h want 42", bus.imem_addr); end
  endtask

  task automatic test_wrap();
    do_reset();
    clear_mem();
    mem[0] = 8'hC0; mem[1] = 8'hFF; mem[8'hFF] = 8'h00;
    pulse_start();
    repeat (4) tick();
    tests++; if (bus.imem_addr !== 8'hFF) begin fails++; $display("FAIL wrap fetch at ff: got %0h want ff", bus.imem_addr); end
    tick();
    tests++; if (bus.pc !== 8'h00) begin fails++; $display("FAIL wrap pc after ff fetch: got %0h want 00", bus.pc); end
    repeat (2) tick();
    tests++; if ({bus.imem_addr, bus.pc} !== 16'h0000) begin fails++; $display("FAIL wrap next fetch addr/pc: got %0h want 0000", {bus.imem_addr, bus.pc}); end
    tick();
    tests++; if (bus.pc !== 8'h01) begin fails++; $display("FAIL wrap pc after fetch at 00: got %0h want 01", bus.pc); end
  endtask

  task automatic test_halt_resume();
    do_reset();
    clear_mem();
    mem[0] = 8'h17; mem[1] = 8'hF0; mem[2] = 8'h12; mem[3] = 8'hF0;
    pulse_start();
    repeat (6) tick();
    tests++; if ({bus.halted, bus.pc, bus.imem_addr} !== {1'b1, 8'h02, 8'h02}) begin fails++; $display("FAIL halt entry halted/pc/addr: got %0h want %0h", {bus.halted, bus.pc, bus.imem_addr}, {1'b1, 8'h02, 8'h02}); end
    for (int c = 0; c < 10; c++) begin
      tick();
      tests++; if ({bus.halted, bus.pc, bus.imem_addr, bus.load_acc} !== {1'b1, 8'h02, 8'h02, 1'b0}) begin fails++; $display("FAIL halt hold cycle %0d: got %0h want %0h", c, {bus.halted, bus.pc, bus.imem_addr, bus.load_acc}, {1'b1, 8'h02, 8'h02, 1'b0}); end
    end
    pulse_start();
    tests++; if ({bus.halted, bus.imem_addr} !== {1'b0, 8'h02}) begin fails++; $display("FAIL resume fetch halted/addr: got %0h want %0h", {bus.halted, bus.imem_addr}, {1'b0, 8'h02}); end
    repeat (2) tick();
    tests++; if ({bus.load_acc, bus.immediate} !== {1'b1, 4'd2}) begin fails++; $display("FAIL resumed LDI load/imm: got %0h want %0h", {bus.load_acc, bus.immediate}, {1'b1, 4'd2}); end
    repeat (3) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tests++; if ({bus.halted, bus.pc} !== {1'b1, 8'h04}) begin fails++; $display("FAIL start during EXEC not ignored halted/pc: got %0h want %0h", {bus.halted, bus.pc}, {1'b1, 8'h04}); end
    tick();
    tests++; if ({bus.halted, bus.pc, bus.imem_addr} !== {1'b1, 8'h04, 8'h04}) begin fails++; $display("FAIL second halt hold: got %0h want %0h", {bus.halted, bus.pc, bus.imem_addr}, {1'b1, 8'h04, 8'h04}); end
  endtask

  task automatic test_alu_sweep();
    do_reset();
    clear_mem();
    for (int i = 0; i < 8; i++) mem[i] = 8'((i + 4) << 4) | 8'(i);
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      repeat (2) tick();
      tests++; if ({bus.load_acc, bus.sel_acc[1], bus.alu_op} !== {1'b1, 1'b1, 3'(i)}) begin fails++; $display("FAIL alu sweep op %0h load/sel1/alu: got %0h want %0h", i + 4, {bus.load_acc, bus.sel_acc[1], bus.alu_op}, {1'b1, 1'b1, 3'(i)}); end
      tick();
      tests++; if (bus.load_acc !== 1'b0) begin fails++; $display("FAIL alu sweep op %0h load width: got %b want 0", i + 4, bus.load_acc); end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 20; r++) begin
      exp_t q[$];
      exp_t e;
      logic [7:0] pc, p1, p2, a, tgt;
      logic [7:0] regs [16];
      logic [3:0] op, opd;
      bit taken;
      do_reset();
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      pc = 8'h00; a = 8'h00;
      for (int i = 0; i < 16; i++) regs[i] = 8'h00;
      for (int n = 0; n < 30; n++) begin
        op = mem[pc][7:4]; opd = mem[pc][3:0];
        p1 = pc + 8'd1; p2 = pc + 8'd2;
        q.push_back(mk(pc, pc, 1'b0));
        q.push_back(mk(p1, p1, 1'b0));
        if (op >= OP_JMP && op != OP_HLT) begin
          e = mk(p1, p1, 1'b0);
          e.c_sel = 0; e.c_alu = 0; e.c_imm = 0; e.c_rfa = 0;
          q.push_back(e);
          q.push_back(mk(p2, p2, 1'b0));
          tgt = mem[p1];
          taken = (op == OP_JMP) || (op == OP_JZ && a == 0) || (op == OP_JNZ && a != 0);
          pc = taken ? tgt : p2;
        end else begin
          e = mk(8'h00, p1, 1'b0);
          e.c_sel = 0; e.c_alu = 0; e.c_imm = 0; e.c_rfa = 0;
          if (op == OP_LDI) begin
            e.load = 1; e.sel = 2'b00; e.c_sel = 1; e.imm = opd; e.c_imm = 1; a = {4'h0, opd};
          end else if (op == OP_LDR) begin
            e.load = 1; e.sel = 2'b01; e.c_sel = 1; e.rfa = opd; e.c_rfa = 1; a = regs[opd];
          end else if (op == OP_STR) begin
            e.we = 1; e.rfa = opd; e.c_rfa = 1; regs[opd] = a;
          end else if (op >= OP_ADD) begin
            if (op != OP_HLT) begin
              e.load = 1; e.sel = 2'b10; e.c_sel = 1; e.alu = 3'(op - 4'd4); e.c_alu = 1;
              e.rfa = opd; e.c_rfa = 1; a = alu_f(3'(op - 4'd4), a, regs[opd]);
            end
          end
          q.push_back(e);
          pc = p1;
          if (op == OP_HLT) begin
            q.push_back(mk(pc, pc, 1'b1));
            q.push_back(mk(pc, pc, 1'b1));
            break;
          end
        end
      end
      pulse_start();
      foreach (q[i]) begin
        if (i > 0) tick();
        tests++; if (bus.imem_addr !== q[i].addr) begin fails++; $display("FAIL random run %0d cycle %0d imem_addr: got %0h want %0h", r, i, bus.imem_addr, q[i].addr); end
        tests++; if (bus.pc !== q[i].pc) begin fails++; $display("FAIL random run %0d cycle %0d pc: got %0h want %0h", r, i, bus.pc, q[i].pc); end
        tests++; if ({bus.load_acc, bus.rf_we, bus.halted} !== {q[i].load, q[i].we, q[i].halted}) begin fails++; $display("FAIL random run %0d cycle %0d load/we/halted: got %b want %b", r, i, {bus.load_acc, bus.rf_we, bus.halted}, {q[i].load, q[i].we, q[i].halted}); end
        if (q[i].c_sel) begin tests++; if (bus.sel_acc !== q[i].sel) begin fails++; $display("FAIL random run %0d cycle %0d sel_acc: got %0h want %0h", r, i, bus.sel_acc, q[i].sel); end end
        if (q[i].c_alu) begin tests++; if (bus.alu_op !== q[i].alu) begin fails++; $display("FAIL random run %0d cycle %0d alu_op: got %0h want %0h", r, i, bus.alu_op, q[i].alu); end end
        if (q[i].c_imm) begin tests++; if (bus.immediate !== q[i].imm) begin fails++; $display("FAIL random run %0d cycle %0d immediate: got %0h want %0h", r, i, bus.immediate, q[i].imm); end end
        if (q[i].c_rfa) begin tests++; if (bus.rf_addr !== q[i].rfa) begin fails++; $display("FAIL random run %0d cycle %0d rf_addr: got %0h want %0h", r, i, bus.rf_addr, q[i].rfa); end end
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clb = 1'b1;
    bus.start = 1'b0;
    clear_mem();
    test_reset();
    test_straight_line();
    test_jumps();
    test_wrap();
    test_halt_resume();
    test_alu_sweep();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
